// File: rtl/mul_issue_station_if.sv
// Dispatch, CDB, multiplier and writeback signals of the multiply reservation station.
interface mul_issue_station_if #(
  parameter int unsigned TAG_W = 5
);
  logic             disp_valid;
  logic             disp_ready;
  logic [4:0]       disp_op;
  logic [TAG_W-1:0] disp_tag;
  logic [31:0]      disp_rs1_val;
  logic             disp_rs1_rdy;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [31:0]      disp_rs2_val;
  logic             disp_rs2_rdy;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             mul_start;
  logic [4:0]       mul_op_sel;
  logic [31:0]      mul_rs1;
  logic [31:0]      mul_rs2;
  logic             mul_done;
  logic [31:0]      mul_result;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;

  // Station side.
  modport slave (
    input  disp_valid, disp_op, disp_tag,
    input  disp_rs1_val, disp_rs1_rdy, disp_rs1_tag,
    input  disp_rs2_val, disp_rs2_rdy, disp_rs2_tag,
    input  cdb_valid, cdb_tag, cdb_data,
    input  mul_done, mul_result,
    output disp_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2,
    output wb_valid, wb_tag, wb_data
  );

  // Dispatch/CDB/multiplier side.
  modport master (
    output disp_valid, disp_op, disp_tag,
    output disp_rs1_val, disp_rs1_rdy, disp_rs1_tag,
    output disp_rs2_val, disp_rs2_rdy, disp_rs2_tag,
    output cdb_valid, cdb_tag, cdb_data,
    output mul_done, mul_result,
    input  disp_ready, mul_start, mul_op_sel, mul_rs1, mul_rs2,
    input  wb_valid, wb_tag, wb_data
  );
endinterface

// File: rtl/mul_issue_station.sv
// Reservation station feeding a pipelined RV32M multiplier: buffers ops, snoops the CDB,
// issues the oldest ready op each cycle and re-pairs results with their tags at writeback.
module mul_issue_station #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  mul_issue_station_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      rs1_val;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs2_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
  } entry_t;

  logic [DEPTH-1:0]   valid_q, valid_d;
  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [DEPTH-1:0]   older_q [DEPTH];
  logic [DEPTH-1:0]   older_d [DEPTH];
  logic [MUL_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [TAG_W-1:0]   dl_tag_q [MUL_LAT];
  logic [TAG_W-1:0]   dl_tag_d [MUL_LAT];

  logic             free_found;
  logic [IdxW-1:0]  free_idx;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] oldest;
  logic [IdxW-1:0]  issue_idx;
  logic             issue_any;
  logic             mul_start;
  logic             disp_ready;
  logic             disp_fire;
  logic             wb_valid;
  entry_t           disp_entry;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  // Oldest candidate: no other candidate is older than it.
  always_comb begin
    cand      = '0;
    oldest    = '0;
    issue_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] & entry_q[i].rs1_rdy & entry_q[i].rs2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && older_q[j][i]) begin
          oldest[i] = 1'b0;
        end
      end
      if (oldest[i]) begin
        issue_idx = IdxW'(i);
      end
    end
  end

  assign issue_any  = |cand;
  assign mul_start  = issue_any & ~flush_i;
  assign disp_ready = ~(&valid_q) & ~flush_i;
  assign disp_fire  = bus.disp_valid & disp_ready;

  // Incoming entry with same-cycle CDB bypass.
  always_comb begin
    disp_entry = '{
      op:      bus.disp_op,
      tag:     bus.disp_tag,
      rs1_val: bus.disp_rs1_val,
      rs1_rdy: bus.disp_rs1_rdy,
      rs1_tag: bus.disp_rs1_tag,
      rs2_val: bus.disp_rs2_val,
      rs2_rdy: bus.disp_rs2_rdy,
      rs2_tag: bus.disp_rs2_tag
    };
    if (!bus.disp_rs1_rdy && bus.cdb_valid && (bus.disp_rs1_tag == bus.cdb_tag)) begin
      disp_entry.rs1_val = bus.cdb_data;
      disp_entry.rs1_rdy = 1'b1;
    end
    if (!bus.disp_rs2_rdy && bus.cdb_valid && (bus.disp_rs2_tag == bus.cdb_tag)) begin
      disp_entry.rs2_val = bus.cdb_data;
      disp_entry.rs2_rdy = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && bus.cdb_valid) begin
        if (!entry_q[i].rs1_rdy && (entry_q[i].rs1_tag == bus.cdb_tag)) begin
          entry_d[i].rs1_val = bus.cdb_data;
          entry_d[i].rs1_rdy = 1'b1;
        end
        if (!entry_q[i].rs2_rdy && (entry_q[i].rs2_tag == bus.cdb_tag)) begin
          entry_d[i].rs2_val = bus.cdb_data;
          entry_d[i].rs2_rdy = 1'b1;
        end
      end
    end
    if (mul_start) begin
      valid_d[issue_idx] = 1'b0;
    end
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      entry_d[free_idx] = disp_entry;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][free_idx] = (j != int'(free_idx));
      end
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_comb begin
    dl_valid_d    = '0;
    dl_valid_d[0] = mul_start;
    dl_tag_d[0]   = entry_q[issue_idx].tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_tag_d[i]   = dl_tag_q[i-1];
    end
    if (flush_i) begin
      dl_valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      dl_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        older_q[i] <= '0;
      end
      for (int i = 0; i < MUL_LAT; i++) begin
        dl_tag_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      entry_q    <= entry_d;
      older_q    <= older_d;
      dl_valid_q <= dl_valid_d;
      dl_tag_q   <= dl_tag_d;
    end
  end

  always_comb begin
    bus.mul_op_sel = '0;
    bus.mul_rs1    = '0;
    bus.mul_rs2    = '0;
    if (mul_start) begin
      bus.mul_op_sel = entry_q[issue_idx].op;
      bus.mul_rs1    = entry_q[issue_idx].rs1_val;
      bus.mul_rs2    = entry_q[issue_idx].rs2_val;
    end
  end

  // Flushed ops still raise mul_done; their cleared delay-line valid suppresses writeback.
  assign wb_valid       = bus.mul_done & dl_valid_q[MUL_LAT-1];
  assign bus.disp_ready = disp_ready;
  assign bus.mul_start  = mul_start;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_tag     = wb_valid ? dl_tag_q[MUL_LAT-1] : '0;
  assign bus.wb_data    = wb_valid ? bus.mul_result : '0;

endmodule

// File: tb/tb_mul_issue_station.sv
// Bench for mul_issue_station: behavioural 4-cycle multiplier plus a writeback scoreboard.
module tb_mul_issue_station;

  localparam int unsigned MulLat = 4;
  localparam logic [4:0] OpMul    = 5'b10000;
  localparam logic [4:0] OpMulh   = 5'b10001;
  localparam logic [4:0] OpMulhsu = 5'b10010;
  localparam logic [4:0] OpMulhu  = 5'b10011;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  sb_t  sb_q [$];
  sb_t  exp_wb;
  int unsigned since_flush = 0;

  logic        md_v [MulLat];
  logic [31:0] md_r [MulLat];

  mul_issue_station_if #(.TAG_W(5)) bus ();

  mul_issue_station #(
    .DEPTH  (4),
    .TAG_W  (5),
    .MUL_LAT(MulLat)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OpMulh || op == OpMulhsu) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == OpMulh) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == OpMul) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model; also tracks cycles since the last flush/reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MulLat; i++) begin
        md_v[i] <= 1'b0;
        md_r[i] <= '0;
      end
      since_flush <= 0;
    end else begin
      md_v[0] <= bus.mul_start;
      md_r[0] <= mul_ref(bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2);
      for (int i = 1; i < MulLat; i++) begin
        md_v[i] <= md_v[i-1];
        md_r[i] <= md_r[i-1];
      end
      since_flush <= flush ? 0 : ((since_flush < 1000) ? since_flush + 1 : since_flush);
    end
  end

  assign bus.mul_done   = md_v[MulLat-1];
  assign bus.mul_result = md_r[MulLat-1];

  // Writeback monitor: scoreboard pop and done/valid invariant.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && since_flush >= MulLat) begin
        n_cmp++;
        if (bus.wb_valid !== bus.mul_done) begin
          n_fail++;
          $display("FAIL invariant: wb_valid=%b but mul_done=%b", bus.wb_valid, bus.mul_done);
        end
      end
      if (bus.wb_valid === 1'b1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got tag %0d data %h, want no writeback",
                   bus.wb_tag, bus.wb_data);
        end else begin
          exp_wb = sb_q.pop_front();
          if ({bus.wb_tag, bus.wb_data} !== {exp_wb.tag, exp_wb.data}) begin
            n_fail++;
            $display("FAIL wb_data: got tag %0d data %h, want tag %0d data %h",
                     bus.wb_tag, bus.wb_data, exp_wb.tag, exp_wb.data);
          end
        end
      end
    end
  end

  task automatic idle();
    bus.disp_valid   = 1'b0;
    bus.disp_op      = '0;
    bus.disp_tag     = '0;
    bus.disp_rs1_val = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs1_tag = '0;
    bus.disp_rs2_val = '0;
    bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs2_tag = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    flush            = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_disp(input logic [4:0] op, input logic [4:0] tag,
                            input logic [31:0] v1, input logic r1, input logic [4:0] t1,
                            input logic [31:0] v2, input logic r2, input logic [4:0] t2);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_tag     = tag;
    bus.disp_rs1_val = v1;
    bus.disp_rs1_rdy = r1;
    bus.disp_rs1_tag = t1;
    bus.disp_rs2_val = v2;
    bus.disp_rs2_rdy = r2;
    bus.disp_rs2_tag = t2;
  endtask

  task automatic drive_cdb(input logic [4:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.disp_ready, bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2, bus.wb_valid}
        !== {1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b start=%b op=%h rs1=%h rs2=%h wb=%b, want 1 0 0 0 0 0",
               bus.disp_ready, bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2,
               bus.wb_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_ready_dispatch();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin
        drive_disp(OpMul, 5'd3, 32'd7, 1'b1, 5'd0, 32'd6, 1'b1, 5'd0);
        sb_q.push_back('{tag: 5'd3, data: 32'd42});
      end
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if ({bus.disp_ready, bus.mul_start} !== 2'b10) begin
          n_fail++;
          $display("FAIL ready_c0: got rdy=%b start=%b, want 1 0", bus.disp_ready, bus.mul_start);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2}
            !== {1'b1, OpMul, 32'd7, 32'd6}) begin
          n_fail++;
          $display("FAIL ready_issue: got start=%b op=%h rs1=%h rs2=%h, want 1 10 7 6",
                   bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({bus.wb_valid, bus.wb_tag, bus.wb_data} !== {1'b1, 5'd3, 32'd42}) begin
          n_fail++;
          $display("FAIL ready_wb: got v=%b tag=%0d data=%h, want 1 3 0000002a",
                   bus.wb_valid, bus.wb_tag, bus.wb_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_wakeup();
    for (int c = 0; c <= 9; c++) begin
      if (c == 0) begin
        drive_disp(OpMulh, 5'd10, 32'hffff_fffe, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9);
        sb_q.push_back('{tag: 5'd10, data: 32'h0000_0001});
      end
      if (c == 4) drive_cdb(5'd9, 32'h8000_0000);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if (bus.mul_start !== 1'b0) begin
          n_fail++;
          $display("FAIL wakeup_early c%0d: got start=%b, want 0", c, bus.mul_start);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2}
            !== {1'b1, OpMulh, 32'hffff_fffe, 32'h8000_0000}) begin
          n_fail++;
          $display("FAIL wakeup_issue: got start=%b op=%h rs1=%h rs2=%h, want 1 11 fffffffe 80000000",
                   bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if ({bus.wb_valid, bus.wb_tag, bus.wb_data} !== {1'b1, 5'd10, 32'd1}) begin
          n_fail++;
          $display("FAIL wakeup_wb: got v=%b tag=%0d data=%h, want 1 10 00000001",
                   bus.wb_valid, bus.wb_tag, bus.wb_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin
        drive_disp(OpMul, 5'd11, 32'd0, 1'b0, 5'd2, 32'd3, 1'b1, 5'd0);
        drive_cdb(5'd2, 32'd5);
        sb_q.push_back('{tag: 5'd11, data: 32'd15});
      end
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (bus.mul_start !== 1'b0) begin
          n_fail++;
          $display("FAIL bypass_c0: got start=%b, want 0", bus.mul_start);
        end
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_rs1, bus.mul_rs2} !== {1'b1, 32'd5, 32'd3}) begin
          n_fail++;
          $display("FAIL bypass_issue: got start=%b rs1=%h rs2=%h, want 1 5 3",
                   bus.mul_start, bus.mul_rs1, bus.mul_rs2);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_age_full();
    logic [4:0] ops [4];
    ops = '{OpMul, OpMulh, OpMulhsu, OpMulhu};
    for (int c = 0; c <= 12; c++) begin
      if (c <= 3) begin
        drive_disp(ops[c], 5'(c + 1), 32'd0, 1'b0, 5'd17, 32'd0, 1'b0, 5'd17);
        sb_q.push_back('{tag: 5'(c + 1), data: mul_ref(ops[c], 32'hffff_ffff, 32'hffff_ffff)});
      end
      if (c == 4) begin
        // Offered while full: must be ignored.
        drive_disp(OpMul, 5'd30, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        drive_cdb(5'd17, 32'hffff_ffff);
      end
      @(negedge clk);
      if (c <= 3 || c == 4 || c == 5 || c == 6) begin
        n_cmp++;
        if (bus.disp_ready !== ((c <= 3 || c == 6) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL age_ready c%0d: got %b, want %b", c, bus.disp_ready,
                   (c <= 3 || c == 6));
        end
      end
      if (c == 4 || c == 9) begin
        n_cmp++;
        if (bus.mul_start !== 1'b0) begin
          n_fail++;
          $display("FAIL age_idle c%0d: got start=%b, want 0", c, bus.mul_start);
        end
      end
      if (c >= 5 && c <= 8) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2}
            !== {1'b1, ops[c-5], 32'hffff_ffff, 32'hffff_ffff}) begin
          n_fail++;
          $display("FAIL age_issue c%0d: got start=%b op=%h rs1=%h rs2=%h, want 1 %h ffffffff ffffffff",
                   c, bus.mul_start, bus.mul_op_sel, bus.mul_rs1, bus.mul_rs2, ops[c-5]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 9; c++) begin
      if (c <= 3) begin
        drive_disp(OpMul, 5'(c + 12), 32'(c + 2), 1'b1, 5'd0, 32'(c + 100), 1'b1, 5'd0);
        sb_q.push_back('{tag: 5'(c + 12), data: mul_ref(OpMul, 32'(c + 2), 32'(c + 100))});
      end
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_rs1, bus.mul_rs2} !== {1'b1, 32'(c + 1), 32'(c + 99)}) begin
          n_fail++;
          $display("FAIL b2b_issue c%0d: got start=%b rs1=%0d rs2=%0d, want 1 %0d %0d",
                   c, bus.mul_start, bus.mul_rs1, bus.mul_rs2, c + 1, c + 99);
        end
      end
      if (c >= 5 && c <= 8) begin
        n_cmp++;
        if ({bus.wb_valid, bus.wb_tag} !== {1'b1, 5'(c + 7)}) begin
          n_fail++;
          $display("FAIL b2b_wb c%0d: got v=%b tag=%0d, want 1 %0d",
                   c, bus.wb_valid, bus.wb_tag, c + 7);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c <= 7; c++) begin
      if (c == 0) drive_disp(OpMul, 5'd6, 32'd3, 1'b1, 5'd0, 32'd3, 1'b1, 5'd0);
      if (c == 1) drive_disp(OpMul, 5'd7, 32'd4, 1'b1, 5'd0, 32'd0, 1'b0, 5'd18);
      if (c == 3) begin
        flush = 1'b1;
        drive_disp(OpMul, 5'd19, 32'd1, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
        drive_cdb(5'd18, 32'd2);
      end
      if (c == 4) drive_cdb(5'd18, 32'd2);
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_rs1} !== {1'b1, 32'd3}) begin
          n_fail++;
          $display("FAIL flush_issue: got start=%b rs1=%h, want 1 3", bus.mul_start, bus.mul_rs1);
        end
      end
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if ({bus.disp_ready, bus.mul_start} !== {(c != 3), 1'b0}) begin
          n_fail++;
          $display("FAIL flush_state c%0d: got rdy=%b start=%b, want %b 0",
                   c, bus.disp_ready, bus.mul_start, (c != 3));
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({bus.mul_done, bus.wb_valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL flush_wb: got done=%b wb_valid=%b, want 1 0", bus.mul_done, bus.wb_valid);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) drive_disp(OpMul, 5'd8, 32'd2, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0);
      if (c == 1) drive_disp(OpMul, 5'd9, 32'd2, 1'b1, 5'd0, 32'd0, 1'b0, 5'd21);
      if (c == 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.disp_ready, bus.mul_start, bus.wb_valid} !== 3'b100) begin
          n_fail++;
          $display("FAIL areset_clear: got rdy=%b start=%b wb=%b, want 1 0 0",
                   bus.disp_ready, bus.mul_start, bus.wb_valid);
        end
      end
      if (c == 3) begin
        rst_n = 1'b1;
        drive_cdb(5'd21, 32'd7);
      end
      @(negedge clk);
      if (c == 4 || c == 5) begin
        n_cmp++;
        if ({bus.mul_start, bus.mul_done, bus.wb_valid} !== 3'b000) begin
          n_fail++;
          $display("FAIL areset_after c%0d: got start=%b done=%b wb=%b, want 0 0 0",
                   c, bus.mul_start, bus.mul_done, bus.wb_valid);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_age_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    for (int i = 0; i < 6; i++) next_cycle();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending writebacks, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue_station.md
Name: mul_issue_station

Overview:
- Reservation station and issue stage directly upstream of the 4-cycle pipelined RV32M multiplier. The multiplier's busy is always 0 and it accepts one operation per cycle.
- Buffers dispatched MUL/MULH/MULHSU/MULHU ops and snoops the CDB for pending operands.
- Issues the oldest fully-ready op each cycle into the multiplier.
- Carries each op's ROB tag through a delay line matched to multiplier latency, so the multiplier's done/result are paired with their tag at writeback.

Parameters:
DEPTH, 4, number of station entries (2..8)
TAG_W, 5, ROB/physical tag width
MUL_LAT, 4, multiplier start-to-done latency in cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  pipeline flush (mispredict/exception)
disp_valid  in  1  dispatch request
disp_ready  out  1  a free entry exists
disp_op  in  5  op_sel, 10000..10011
disp_tag  in  TAG_W  destination tag
disp_rs1_val  in  32  operand 1 value
disp_rs1_rdy  in  1  operand 1 value valid
disp_rs1_tag  in  TAG_W  producer tag of operand 1
disp_rs2_val  in  32  operand 2 value
disp_rs2_rdy  in  1  operand 2 value valid
disp_rs2_tag  in  TAG_W  producer tag of operand 2
cdb_valid  in  1  common data bus broadcast
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  32  broadcast value
mul_start  out  1  to multiplier start
mul_op_sel  out  5  to multiplier op_sel
mul_rs1  out  32  to multiplier rs1
mul_rs2  out  32  to multiplier rs2
mul_done  in  1  from multiplier done
mul_result  in  32  from multiplier result
wb_valid  out  1  writeback request
wb_tag  out  TAG_W  tag of writeback result
wb_data  out  32  writeback value

Behaviour:
- Reset (async): all entries invalid, all age state cleared, all delay-line valids 0. After reset: disp_ready=1, mul_start=0, mul_op_sel/mul_rs1/mul_rs2=0, wb_valid=0.
- Entry contents: valid, op, tag, rs1/rs2 value, ready bit and producer tag per operand, dispatch age.
- disp_ready:
  - = (any entry invalid) & ~flush.
  - Computed from registered state only; an entry freed by same-cycle issue does not raise it.
- Dispatch (disp_valid & disp_ready):
  - Written at the clock edge into the lowest-index free entry.
  - Is youngest in age order.
  - Same-cycle CDB bypass: an operand with rdy=0 whose tag equals cdb_tag while cdb_valid=1 is stored ready with cdb_data.
- CDB snoop, every cycle: each valid entry with a not-ready operand whose tag matches cdb_tag while cdb_valid=1 captures cdb_data and sets ready. Both operands of one entry may capture in the same cycle.
- Issue select: combinational over registered entry state.
  - Candidate = valid & rs1 ready & rs2 ready.
  - Chooses the oldest candidate.
  - An entry dispatched or woken at edge N is first eligible in cycle N+1; there is no same-cycle CDB-to-issue bypass.
- Issue outputs:
  - mul_start = candidate exists & ~flush.
  - mul_op_sel/mul_rs1/mul_rs2 = chosen entry's fields; all 0 when mul_start=0.
  - Chosen entry is invalidated at the edge.
  - Throughput: one issue per cycle.
  - A dispatch and an issue may both occur in the same cycle.
- Tag delay line: MUL_LAT stages of {valid, tag}, shifting every cycle.
  - Stage 0 loads {mul_start, chosen tag}.
  - Op issued in cycle N reaches the last stage in cycle N+MUL_LAT, coinciding with mul_done.
- Writeback:
  - wb_valid = mul_done & last-stage valid.
  - wb_tag = last-stage tag.
  - wb_data = mul_result.
  - When wb_valid=0, wb_tag and wb_data are don't-care but driven to 0.
- Flush:
  - Highest priority: no dispatch accepted, mul_start=0, nothing captured.
  - At the edge, all entries and all delay-line valids are cleared.
  - Multiplier ops already in flight still raise mul_done; they are suppressed at writeback because their delay-line valid is 0.
- Age: DEPTH x DEPTH older-than matrix, or per-entry counters. Either way, strict dispatch order and no ties.
- Invariant, checked by bench: mul_done == last-stage valid whenever no flush occurred within the preceding MUL_LAT cycles.

Test Plan:
- Ready dispatch: MUL, rs1=7, rs2=6, both rdy, tag=3 in cycle 0 -> mul_start in cycle 1. wb_valid in cycle 5 with wb_tag=3, wb_data=42.
- Operand wakeup: MULH, rs1 rdy=-2, rs2 pending on tag 9. CDB {9, 0x80000000} in cycle 4 -> issue in cycle 5 with mul_rs2=0x80000000. Writeback in cycle 9 with wb_data=0x00000001.
- Same-cycle bypass: dispatch with rs1_tag=2 not ready while cdb_valid with tag 2 and data 5 -> entry stored ready; issue the next cycle with mul_rs1=5.
- Age order and full:
  - Fill DEPTH=4 entries (tags 1..4) with all operands pending; disp_ready=0.
  - Broadcast all operand tags in one cycle -> issues on 4 consecutive cycles in tag order 1, 2, 3, 4.
  - disp_ready returns to 1 one cycle after the first issue.
- Back-to-back throughput: 4 ready dispatches on consecutive cycles -> mul_start high for 4 consecutive cycles; wb_valid high for 4 consecutive cycles with the correct tags.
- Flush mid-flight:
  - Issue tag 6 in cycle 1; flush in cycle 3.
  - No wb_valid in cycle 5 despite mul_done=1.
  - Station is empty and disp_ready=1 in cycle 4.
  - Asserting rst_n low mid-operation gives the same clearing asynchronously.
